// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared structs and constants for the reorder buffer slice.
//   ROB_DEPTH / ROB_TAG_W : entry count and tag width (DEPTH == 2**TAG_W)
//   itype_e               : instruction class carried in each entry
//   ROB_entry_t           : per-entry payload presented at head/allocation
//   CDB_packet_t          : common data bus broadcast
package reorder_buffer_pkg;

   localparam int unsigned ROB_DEPTH = 16;
   localparam int unsigned ROB_TAG_W = 4;

   typedef enum logic [1:0] {
      ITYPE_BRANCH = 2'b00,
      ITYPE_ALU    = 2'b01,
      ITYPE_LOAD   = 2'b10,
      ITYPE_STORE  = 2'b11
   } itype_e;

   typedef struct packed {
      itype_e                 itype;
      logic [4:0]             dest_reg;
      logic [ROB_TAG_W-1:0]   ROB_number;
      logic                   ready;
      logic [31:0]            value;
      logic                   branch_result;
   } ROB_entry_t;

   typedef struct packed {
      logic [ROB_TAG_W-1:0]   tag;
      logic [31:0]            result;
      logic                   branch_result;
      logic                   from_commit;
      logic                   load_step1;
   } CDB_packet_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: dispatch/CDB/commit signal bundle of the reorder buffer.
//   master : dispatch + commit side (drives allocate, CDB, dequeue, lookup tags)
//   slave  : the reorder buffer itself
interface reorder_buffer_if;
   import reorder_buffer_pkg::*;

   logic                   flush;
   logic                   wr_en;
   ROB_entry_t             alloc_entry;
   logic [ROB_TAG_W-1:0]   alloc_ROB;
   logic                   full;
   logic                   cdb_valid;
   CDB_packet_t            cdb;
   logic                   rd_en;
   ROB_entry_t             head;
   logic                   rob_head_ready;
   logic                   empty;
   logic [ROB_TAG_W-1:0]   q_tag0;
   logic [ROB_TAG_W-1:0]   q_tag1;
   logic                   q_ready0;
   logic                   q_ready1;
   logic [31:0]            q_value0;
   logic [31:0]            q_value1;

   modport master (
      output flush, wr_en, alloc_entry, cdb_valid, cdb, rd_en, q_tag0, q_tag1,
      input  alloc_ROB, full, head, rob_head_ready, empty,
             q_ready0, q_ready1, q_value0, q_value1
   );

   modport slave (
      input  flush, wr_en, alloc_entry, cdb_valid, cdb, rd_en, q_tag0, q_tag1,
      output alloc_ROB, full, head, rob_head_ready, empty,
             q_ready0, q_ready1, q_value0, q_value1
   );

endinterface

// File: rtl/reorder_buffer_rob_lookup.sv
// rob_lookup: combinational tag-indexed operand read.
//   valid/ready/value : per-entry state vectors from the buffer
//   tag               : entry to read
//   q_ready/q_value   : ready flag and value, both '0 when the entry is invalid
module rob_lookup
   import reorder_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = ROB_DEPTH,
   parameter int unsigned TAG_W = ROB_TAG_W
) (
   input  logic [DEPTH-1:0]   valid,
   input  logic [DEPTH-1:0]   ready,
   input  logic [31:0]        value [DEPTH],
   input  logic [TAG_W-1:0]   tag,
   output logic               q_ready,
   output logic [31:0]        q_value
);

   always_comb begin
      q_ready = 1'b0;
      q_value = '0;
      if (valid[tag]) begin
         q_ready = ready[tag];
         q_value = value[tag];
      end
   end

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: 16-entry circular reorder buffer between dispatch and commit.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   rob   : reorder_buffer_if.slave (allocate, CDB capture, head/dequeue,
//           two operand lookup ports, flush)
// Optional feature: define ROB_HEAD_BYPASS_EN to forward a CDB result aimed at
// the head entry to head/rob_head_ready in the same cycle.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = ROB_DEPTH,
   parameter int unsigned TAG_W = ROB_TAG_W
) (
   input  logic               clk,
   input  logic               reset,
   reorder_buffer_if.slave    rob
);

   localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

   ROB_entry_t          entries [DEPTH];
   logic [DEPTH-1:0]    valid;
   logic [TAG_W-1:0]    head_ptr;
   logic [TAG_W-1:0]    tail_ptr;
   logic [TAG_W:0]      count;

   logic                do_alloc;
   logic                do_deq;
   logic                cdb_hit;
   ROB_entry_t          alloc_ent;
   ROB_entry_t          head_ent;
   logic [DEPTH-1:0]    ent_ready;
   logic [31:0]         ent_value [DEPTH];
   logic                q_ready0;
   logic                q_ready1;
   logic [31:0]         q_value0;
   logic [31:0]         q_value1;

   assign rob.full      = (count == FULL_COUNT);
   assign rob.empty     = (count == '0);
   assign rob.alloc_ROB = tail_ptr;

   assign do_alloc = rob.wr_en & ~rob.full;
   assign do_deq   = rob.rd_en & ~rob.empty;
   assign cdb_hit  = rob.cdb_valid & ~rob.cdb.from_commit & ~rob.cdb.load_step1
                     & valid[rob.cdb.tag];

   // Branches keep the allocated immediate as their value; everything else
   // starts at zero and is filled by the CDB.
   always_comb begin
      alloc_ent               = rob.alloc_entry;
      alloc_ent.ROB_number    = tail_ptr;
      alloc_ent.ready         = 1'b0;
      alloc_ent.branch_result = 1'b0;
      if (rob.alloc_entry.itype != ITYPE_BRANCH) begin
         alloc_ent.value = '0;
      end
   end

   // The dequeue clear is written after the CDB update so it wins when both
   // hit the head entry in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid    <= '0;
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else if (rob.flush) begin
         valid    <= '0;
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entries[i].ready <= 1'b0;
         end
      end else begin
         if (cdb_hit) begin
            entries[rob.cdb.tag].ready <= 1'b1;
            if (entries[rob.cdb.tag].itype == ITYPE_BRANCH) begin
               entries[rob.cdb.tag].branch_result <= rob.cdb.branch_result;
            end else begin
               entries[rob.cdb.tag].value <= rob.cdb.result;
            end
         end
         if (do_alloc) begin
            entries[tail_ptr] <= alloc_ent;
            valid[tail_ptr]   <= 1'b1;
            tail_ptr          <= tail_ptr + TAG_W'(1);
         end
         if (do_deq) begin
            valid[head_ptr]         <= 1'b0;
            entries[head_ptr].ready <= 1'b0;
            head_ptr                <= head_ptr + TAG_W'(1);
         end
         case ({do_alloc, do_deq})
            2'b10:   count <= count + (TAG_W+1)'(1);
            2'b01:   count <= count - (TAG_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      head_ent = valid[head_ptr] ? entries[head_ptr] : '0;
`ifdef ROB_HEAD_BYPASS_EN
      if (cdb_hit && (rob.cdb.tag == head_ptr)) begin
         head_ent.ready = 1'b1;
         if (head_ent.itype == ITYPE_BRANCH) begin
            head_ent.branch_result = rob.cdb.branch_result;
         end else begin
            head_ent.value = rob.cdb.result;
         end
      end
`endif
      rob.head           = head_ent;
      rob.rob_head_ready = head_ent.ready;
   end

   always_comb begin
      ent_ready = '0;
      ent_value = '{default: '0};
      for (int unsigned i = 0; i < DEPTH; i++) begin
         ent_ready[i] = entries[i].ready;
         ent_value[i] = entries[i].value;
      end
   end

   rob_lookup #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_lookup0 (
      .valid   (valid),
      .ready   (ent_ready),
      .value   (ent_value),
      .tag     (rob.q_tag0),
      .q_ready (q_ready0),
      .q_value (q_value0)
   );

   rob_lookup #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_lookup1 (
      .valid   (valid),
      .ready   (ent_ready),
      .value   (ent_value),
      .tag     (rob.q_tag1),
      .q_ready (q_ready1),
      .q_value (q_value1)
   );

   assign rob.q_ready0 = q_ready0;
   assign rob.q_ready1 = q_ready1;
   assign rob.q_value0 = q_value0;
   assign rob.q_value1 = q_value1;

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: scoreboard bench for reorder_buffer. The reference model
// is a program-ordered queue of entries; expected per-cycle outputs are pushed
// by the driver and compared by an independent negedge monitor.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   reorder_buffer_if rif ();

   reorder_buffer #(.DEPTH(16), .TAG_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .rob   (rif)
   );

   typedef struct {
      logic        empty;
      logic        full;
      logic [3:0]  alloc_rob;
      ROB_entry_t  head;
      logic        head_ready;
      logic        qr0;
      logic [31:0] qv0;
      logic        qr1;
      logic [31:0] qv1;
   } exp_t;

   exp_t          exp_q [$];
   exp_t          me;
   ROB_entry_t    m_q [$];
   int unsigned   m_tail = 0;
   int            n_checks = 0;
   int            n_fail = 0;

   // stimulus for the next cycle
   logic          s_wr, s_rd, s_cv, s_fl;
   ROB_entry_t    s_ent;
   CDB_packet_t   s_cdb;
   logic [3:0]    s_qt0, s_qt1;

   function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp_v);
      n_checks++;
      if (got !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp_v, $time);
      end
   endfunction

   function automatic void idle();
      s_wr = 1'b0; s_rd = 1'b0; s_cv = 1'b0; s_fl = 1'b0;
      s_ent = '0; s_cdb = '0;
   endfunction

   function automatic ROB_entry_t rand_ent(bit allow_branch);
      ROB_entry_t e;
      e.itype         = allow_branch ? itype_e'(2'($urandom_range(0, 3)))
                                     : itype_e'(2'($urandom_range(1, 3)));
      e.dest_reg      = 5'($urandom);
      e.ROB_number    = 4'($urandom);
      e.ready         = 1'($urandom);
      e.value         = $urandom;
      e.branch_result = 1'($urandom);
      return e;
   endfunction

   function automatic void lookup(input logic [3:0] t, output logic r, output logic [31:0] v);
      r = 1'b0;
      v = '0;
      foreach (m_q[i]) begin
         if (m_q[i].ROB_number == t) begin
            r = m_q[i].ready;
            v = m_q[i].value;
         end
      end
   endfunction

   task automatic drive();
      rif.flush       = s_fl;
      rif.wr_en       = s_wr;
      rif.alloc_entry = s_ent;
      rif.cdb_valid   = s_cv;
      rif.cdb         = s_cdb;
      rif.rd_en       = s_rd;
      rif.q_tag0      = s_qt0;
      rif.q_tag1      = s_qt1;
   endtask

   // One clock cycle: apply stimulus, record expected outputs, advance model.
   task automatic step();
      exp_t        e;
      ROB_entry_t  n;
      int unsigned sz;
      bit          cdb_ok;
      @(posedge clk);
      #1;
      drive();
      sz     = m_q.size();
      cdb_ok = s_cv && !s_cdb.from_commit && !s_cdb.load_step1;
      e.empty     = (sz == 0);
      e.full      = (sz == 16);
      e.alloc_rob = 4'(m_tail);
      e.head      = (sz > 0) ? m_q[0] : '0;
`ifdef ROB_HEAD_BYPASS_EN
      if (cdb_ok && sz > 0 && m_q[0].ROB_number == s_cdb.tag) begin
         e.head.ready = 1'b1;
         if (e.head.itype == ITYPE_BRANCH) e.head.branch_result = s_cdb.branch_result;
         else                              e.head.value = s_cdb.result;
      end
`endif
      e.head_ready = e.head.ready;
      lookup(s_qt0, e.qr0, e.qv0);
      lookup(s_qt1, e.qr1, e.qv1);
      exp_q.push_back(e);

      if (s_fl) begin
         m_q.delete();
         m_tail = 0;
      end else begin
         if (cdb_ok) begin
            foreach (m_q[i]) begin
               if (m_q[i].ROB_number == s_cdb.tag) begin
                  m_q[i].ready = 1'b1;
                  if (m_q[i].itype == ITYPE_BRANCH) m_q[i].branch_result = s_cdb.branch_result;
                  else                              m_q[i].value = s_cdb.result;
               end
            end
         end
         if (s_rd && sz > 0) void'(m_q.pop_front());
         if (s_wr && sz < 16) begin
            n               = s_ent;
            n.ROB_number    = 4'(m_tail);
            n.ready         = 1'b0;
            n.branch_result = 1'b0;
            if (n.itype != ITYPE_BRANCH) n.value = '0;
            m_q.push_back(n);
            m_tail = (m_tail + 1) % 16;
         end
      end
   endtask

   task automatic async_reset_check();
      @(posedge clk);
      #1;
      idle();
      drive();
      #5;
      reset = 1'b1;
      #1;
      chk("arst_empty", 64'(rif.empty), 64'(1));
      chk("arst_full", 64'(rif.full), 64'(0));
      chk("arst_alloc_rob", 64'(rif.alloc_ROB), 64'(0));
      chk("arst_head_ready", 64'(rif.rob_head_ready), 64'(0));
      #1;
      reset = 1'b0;
      m_q.delete();
      m_tail = 0;
   endtask

   // monitor
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            chk("empty", 64'(rif.empty), 64'(me.empty));
            chk("full", 64'(rif.full), 64'(me.full));
            chk("alloc_rob", 64'(rif.alloc_ROB), 64'(me.alloc_rob));
            chk("head", 64'(rif.head), 64'(me.head));
            chk("head_ready", 64'(rif.rob_head_ready), 64'(me.head_ready));
            chk("q_ready0", 64'(rif.q_ready0), 64'(me.qr0));
            chk("q_value0", 64'(rif.q_value0), 64'(me.qv0));
            chk("q_ready1", 64'(rif.q_ready1), 64'(me.qr1));
            chk("q_value1", 64'(rif.q_value1), 64'(me.qv1));
         end
      end
   end

   initial begin
      idle();
      s_qt0 = 4'd0;
      s_qt1 = 4'd1;
      drive();
      #12;
      chk("rst_empty", 64'(rif.empty), 64'(1));
      chk("rst_full", 64'(rif.full), 64'(0));
      chk("rst_alloc_rob", 64'(rif.alloc_ROB), 64'(0));
      chk("rst_head", 64'(rif.head), 64'(0));
      chk("rst_head_ready", 64'(rif.rob_head_ready), 64'(0));
      chk("rst_q_ready0", 64'(rif.q_ready0), 64'(0));
      chk("rst_q_value0", 64'(rif.q_value0), 64'(0));
      #10;
      reset = 1'b0;

      step();
      // three allocations, then CDB DEADBEEF to tag 0, then commit
      for (int i = 0; i < 3; i++) begin
         idle(); s_wr = 1'b1; s_ent = rand_ent(1'b0); step();
      end
      idle(); step();
      s_cv = 1'b1; s_cdb.tag = 4'd0; s_cdb.result = 32'hDEAD_BEEF; step();
      idle(); step();
      s_rd = 1'b1; step();
      idle(); step();

      // fill to full, refused 17th, simultaneous rd+wr while full, wraps tail
      while (m_q.size() < 16) begin
         idle(); s_wr = 1'b1; s_ent = rand_ent(1'b1); step();
      end
      idle(); s_wr = 1'b1; s_ent = rand_ent(1'b1); step();
      idle(); s_wr = 1'b1; s_rd = 1'b1; s_ent = rand_ent(1'b1); step();
      idle(); step();

      // CDB packets that must not capture
      s_cv = 1'b1; s_cdb.tag = m_q[0].ROB_number; s_cdb.result = 32'h1234_5678;
      s_cdb.load_step1 = 1'b1; s_qt0 = m_q[0].ROB_number; step();
      idle(); s_cv = 1'b1; s_cdb.tag = m_q[0].ROB_number; s_cdb.result = 32'h8765_4321;
      s_cdb.from_commit = 1'b1; step();
      idle(); step();
      for (int i = 0; i < 4; i++) begin
         idle(); s_rd = 1'b1; step();
      end
      idle(); s_cv = 1'b1; s_cdb.tag = 4'(m_tail); s_cdb.result = 32'hBAD0_BAD0;
      s_qt1 = 4'(m_tail); step();
      idle(); step();

      // branch entry keeps its immediate
      idle(); s_fl = 1'b1; step();
      idle(); s_wr = 1'b1; s_ent = rand_ent(1'b0); s_ent.itype = ITYPE_BRANCH;
      s_ent.value = 32'd8; step();
      idle(); s_cv = 1'b1; s_cdb.tag = 4'd0; s_cdb.result = 32'd5;
      s_cdb.branch_result = 1'b1; step();
      idle(); s_qt0 = 4'd0; step();

      // flush with 7 entries and every other request active
      for (int i = 0; i < 6; i++) begin
         idle(); s_wr = 1'b1; s_ent = rand_ent(1'b1); step();
      end
      idle(); s_fl = 1'b1; s_wr = 1'b1; s_rd = 1'b1; s_ent = rand_ent(1'b1);
      s_cv = 1'b1; s_cdb.tag = 4'd1; s_cdb.result = 32'hFEED_F00D; step();
      for (int t = 0; t < 16; t++) begin
         idle(); s_qt0 = 4'(t); s_qt1 = 4'(15 - t); step();
      end

      // asynchronous reset with live entries
      for (int i = 0; i < 5; i++) begin
         idle(); s_wr = 1'b1; s_ent = rand_ent(1'b1); step();
      end
      async_reset_check();
      idle(); step();

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         idle();
         s_wr  = ($urandom_range(0, 9) < 6);
         s_ent = rand_ent(1'b1);
         s_rd  = ($urandom_range(0, 9) < 5);
         s_cv  = ($urandom_range(0, 9) < 6);
         if (m_q.size() > 0 && $urandom_range(0, 3) != 0)
            s_cdb.tag = m_q[$urandom_range(0, m_q.size() - 1)].ROB_number;
         else
            s_cdb.tag = 4'($urandom);
         s_cdb.result        = $urandom;
         s_cdb.branch_result = 1'($urandom);
         s_cdb.from_commit   = ($urandom_range(0, 7) == 0);
         s_cdb.load_step1    = ($urandom_range(0, 7) == 0);
         s_fl  = ($urandom_range(0, 59) == 0);
         s_qt0 = 4'($urandom);
         s_qt1 = (m_q.size() > 0) ? m_q[$urandom_range(0, m_q.size() - 1)].ROB_number
                                  : 4'($urandom);
         step();
      end
      idle();
      step();

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
